sdram_dma_reader: RTL and testbench

// - Upstream DMA master for the SDRAM user project. It drives the dma_wbs_* request port and consumes
//   dma_wbs_ack_o, dma_brust_valid and the shared read data.
// - The CPU programs a source address and a word count through a small Wishbone CSR slave. The engine

---
 rtl/sdram_dma_pkg.sv | 35 +++
 rtl/dma_stream_fifo.sv | 62 ++++++
 rtl/sdram_dma_reader.sv | 257 +++++++++++++++++++++++++
 tb/tb_sdram_dma_reader.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_dma_pkg.sv
// ============================================================================
// Module : sdram_dma_pkg
// Brief  : Shared CSR map, status bits and FSM encoding for the SDRAM DMA reader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sdram_dma_pkg;

    localparam logic [7:0]  CSR_CTRL       = 8'h00;
    localparam logic [7:0]  CSR_STATUS     = 8'h04;
    localparam logic [7:0]  CSR_SRC        = 8'h08;
    localparam logic [7:0]  CSR_LEN        = 8'h0C;

    localparam int          CTRL_START_BIT = 0;
    localparam int          CTRL_ABORT_BIT = 1;

    localparam int          STAT_BUSY_BIT  = 0;
    localparam int          STAT_DONE_BIT  = 1;
    localparam int          STAT_ERR_BIT   = 2;

    localparam logic [8:0]  BURST_REGION   = 9'h0F0;
    localparam logic [1:0]  DMA_FUN_READ   = 2'b01;
    localparam logic [22:0] ADDR_WRAP_LAST = 23'h7F_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BEAT  = 2'd2,
        ST_DONE  = 2'd3
    } dma_state_e;

endpackage

`default_nettype wire

// File: rtl/dma_stream_fifo.sv
// ============================================================================
// Module : dma_stream_fifo
// Brief  : Synchronous FIFO with free-slot count; flush beats a same-cycle push.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dma_stream_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_free
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_free    = (AW+1)'(DEPTH) - r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full & ~i_flush;
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

`default_nettype wire

// File: rtl/sdram_dma_reader.sv
// ============================================================================
// Module : sdram_dma_reader
// Brief  : CSR-programmed SDRAM read DMA feeding a valid/ready stream via a FIFO.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sdram_dma_reader
    import sdram_dma_pkg::*;
#(
    parameter logic [31:0] CSR_BASE   = 32'h3800_0000,
    parameter int          BURST_LEN  = 8,
    parameter int          FIFO_DEPTH = 16,
    parameter int          LEN_W      = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        dma_cyc_o,
    output logic        dma_stb_o,
    output logic        dma_we_o,
    output logic [31:0] dma_adr_o,
    output logic [1:0]  dma_fun_sel_o,
    input  logic        dma_ack_i,
    input  logic        dma_brust_i,
    input  logic [31:0] dma_dat_i,
    output logic        m_valid,
    output logic [31:0] m_data,
    input  logic        m_ready,
    output logic        irq_done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BL_W  = $clog2(BURST_LEN) + 1;

    // ---------------------------------------------------------------- CSR slave
    logic             r_wbs_ack;
    logic [31:0]      r_wbs_dat;
    logic [31:0]      r_src;
    logic [LEN_W-1:0] r_len;
    logic             r_start_pulse;
    logic             r_abort_pulse;
    logic             w_csr_hit;
    logic             w_csr_wr;
    logic [7:0]       w_csr_off;
    logic [31:0]      w_rd_data;

    // ---------------------------------------------------------------- engine
    dma_state_e       r_state, w_state_nxt;
    logic             r_cyc, w_cyc_nxt;
    logic [31:0]      r_req_addr, w_req_addr_nxt;
    logic [31:0]      r_cur_addr, w_cur_addr_nxt;
    logic [LEN_W-1:0] r_remaining, w_remaining_nxt;
    logic [BL_W-1:0]  r_beats_left, w_beats_left_nxt;
    logic             r_done, w_done_nxt;
    logic             r_err, w_err_nxt;

    logic             w_busy;
    logic             w_beat;
    logic             w_burst_mode;
    logic             w_wrap;
    logic [31:0]      w_addr_inc;
    logic [BL_W-1:0]  w_eff_burst;
    logic [BL_W-1:0]  w_req_beats;

    logic             w_fifo_push;
    logic             w_fifo_pop;
    logic             w_fifo_flush;
    logic [31:0]      w_fifo_head;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic [CNT_W-1:0] w_fifo_free;

    // Holding ack low for a cycle keeps a lingering strobe from double-acking.
    assign w_csr_hit = wbs_stb_i & wbs_cyc_i & ~r_wbs_ack &
                       (wbs_adr_i[31:8] == CSR_BASE[31:8]);
    assign w_csr_wr  = w_csr_hit & wbs_we_i;
    assign w_csr_off = wbs_adr_i[7:0];

    always_comb begin
        w_rd_data = '0;
        case (w_csr_off)
            CSR_STATUS: begin
                w_rd_data[STAT_BUSY_BIT] = w_busy;
                w_rd_data[STAT_DONE_BIT] = r_done;
                w_rd_data[STAT_ERR_BIT]  = r_err;
            end
            CSR_SRC:    w_rd_data = r_src;
            CSR_LEN:    w_rd_data = 32'(r_len);
            default:    w_rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wbs_ack     <= 1'b0;
            r_wbs_dat     <= '0;
            r_src         <= '0;
            r_len         <= '0;
            r_start_pulse <= 1'b0;
            r_abort_pulse <= 1'b0;
        end else begin
            r_wbs_ack     <= w_csr_hit;
            r_wbs_dat     <= (w_csr_hit && !wbs_we_i) ? w_rd_data : '0;
            r_start_pulse <= w_csr_wr && (w_csr_off == CSR_CTRL) && wbs_dat_i[CTRL_START_BIT];
            r_abort_pulse <= w_csr_wr && (w_csr_off == CSR_CTRL) && wbs_dat_i[CTRL_ABORT_BIT];
            if (w_csr_wr && (w_csr_off == CSR_SRC)) r_src <= {wbs_dat_i[31:2], 2'b00};
            if (w_csr_wr && (w_csr_off == CSR_LEN)) r_len <= wbs_dat_i[LEN_W-1:0];
        end
    end

    assign wbs_ack_o = r_wbs_ack;
    assign wbs_dat_o = r_wbs_dat;

    // ---------------------------------------------------------------- datapath helpers
    assign w_busy       = (r_state == ST_ISSUE) || (r_state == ST_BEAT);
    assign w_beat       = r_cyc & (dma_ack_i | dma_brust_i);
    assign w_burst_mode = (r_cur_addr[31:23] == BURST_REGION);
    assign w_wrap       = (r_cur_addr[22:0] == ADDR_WRAP_LAST);
    assign w_addr_inc   = {r_cur_addr[31:23], r_cur_addr[22:0] + 23'd4};
    assign w_eff_burst  = w_burst_mode ? BL_W'(BURST_LEN) : BL_W'(1);
    assign w_req_beats  = (32'(r_remaining) < 32'(w_eff_burst)) ? BL_W'(r_remaining)
                                                                : w_eff_burst;

    // ---------------------------------------------------------------- FSM next state
    always_comb begin
        w_state_nxt      = r_state;
        w_cyc_nxt        = r_cyc;
        w_req_addr_nxt   = r_req_addr;
        w_cur_addr_nxt   = r_cur_addr;
        w_remaining_nxt  = r_remaining;
        w_beats_left_nxt = r_beats_left;
        w_done_nxt       = r_done;
        w_err_nxt        = r_err;
        w_fifo_push      = 1'b0;
        w_fifo_flush     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_start_pulse) begin
                    if (r_len == '0) begin
                        w_done_nxt = 1'b1;
                        w_err_nxt  = 1'b1;
                    end else begin
                        w_done_nxt      = 1'b0;
                        w_err_nxt       = 1'b0;
                        w_cur_addr_nxt  = r_src;
                        w_remaining_nxt = r_len;
                        w_state_nxt     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // A whole burst must fit before asking, so no beat can ever hit a full FIFO.
                if (w_fifo_free >= CNT_W'(BURST_LEN)) begin
                    w_cyc_nxt        = 1'b1;
                    w_req_addr_nxt   = w_burst_mode ? {BURST_REGION, r_cur_addr[22:0]}
                                                    : r_cur_addr;
                    w_beats_left_nxt = w_req_beats;
                    w_state_nxt      = ST_BEAT;
                end
            end
            ST_BEAT: begin
                if (w_beat) begin
                    w_fifo_push      = 1'b1;
                    w_cur_addr_nxt   = w_addr_inc;
                    w_remaining_nxt  = r_remaining - LEN_W'(1);
                    w_beats_left_nxt = r_beats_left - BL_W'(1);
                    if (w_wrap) w_err_nxt = 1'b1;
                    if (r_beats_left == BL_W'(1)) begin
                        w_cyc_nxt = 1'b0;
                        if (r_remaining == LEN_W'(1)) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_ISSUE;
                        end
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (r_abort_pulse && w_busy) begin
            w_fifo_push  = 1'b0;
            w_fifo_flush = 1'b1;
            w_cyc_nxt    = 1'b0;
            w_done_nxt   = 1'b1;
            w_err_nxt    = 1'b1;
            w_state_nxt  = ST_IDLE;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state      <= ST_IDLE;
            r_cyc        <= 1'b0;
            r_req_addr   <= '0;
            r_cur_addr   <= '0;
            r_remaining  <= '0;
            r_beats_left <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cyc        <= w_cyc_nxt;
            r_req_addr   <= w_req_addr_nxt;
            r_cur_addr   <= w_cur_addr_nxt;
            r_remaining  <= w_remaining_nxt;
            r_beats_left <= w_beats_left_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
        end
    end

    // ---------------------------------------------------------------- stream FIFO
    assign w_fifo_pop = m_valid & m_ready;

    dma_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk         (wb_clk_i),
        .rst         (wb_rst_i),
        .i_push      (w_fifo_push),
        .i_push_data (dma_dat_i),
        .i_pop       (w_fifo_pop),
        .i_flush     (w_fifo_flush),
        .o_head      (w_fifo_head),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full),
        .o_free      (w_fifo_free)
    );

    assign m_valid       = ~w_fifo_empty;
    assign m_data        = w_fifo_empty ? 32'h0 : w_fifo_head;
    assign dma_cyc_o     = r_cyc;
    assign dma_stb_o     = r_cyc;
    assign dma_we_o      = 1'b0;
    assign dma_adr_o     = r_req_addr;
    assign dma_fun_sel_o = w_busy ? DMA_FUN_READ : 2'b00;
    assign irq_done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sdram_dma_reader.sv
// ============================================================================
// Module : tb_sdram_dma_reader
// Brief  : Directed bench with a streaming SDRAM slave model and stream monitor.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sdram_dma_reader;
    import sdram_dma_pkg::*;

    localparam logic [31:0] C_BASE = 32'h3800_0000;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        dma_cyc_o, dma_stb_o, dma_we_o;
    logic [31:0] dma_adr_o;
    logic [1:0]  dma_fun_sel_o;
    logic        dma_ack_i, dma_brust_i;
    logic [31:0] dma_dat_i;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready = 1'b0;
    logic        irq_done;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] slv_seed = '0;
    int          slv_cnt  = 0;
    logic [31:0] rx[$];
    logic [31:0] req_adr[$];
    int          req_beats[$];
    int          beat_total = 0;
    logic        mon_prev_cyc = 1'b0;
    logic        ovf_seen = 1'b0;
    logic [31:0] rd;

    sdram_dma_reader u_dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .wbs_stb_i     (wbs_stb_i),
        .wbs_cyc_i     (wbs_cyc_i),
        .wbs_we_i      (wbs_we_i),
        .wbs_adr_i     (wbs_adr_i),
        .wbs_dat_i     (wbs_dat_i),
        .wbs_ack_o     (wbs_ack_o),
        .wbs_dat_o     (wbs_dat_o),
        .dma_cyc_o     (dma_cyc_o),
        .dma_stb_o     (dma_stb_o),
        .dma_we_o      (dma_we_o),
        .dma_adr_o     (dma_adr_o),
        .dma_fun_sel_o (dma_fun_sel_o),
        .dma_ack_i     (dma_ack_i),
        .dma_brust_i   (dma_brust_i),
        .dma_dat_i     (dma_dat_i),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_ready       (m_ready),
        .irq_done      (irq_done)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge wb_clk_i); #1; end
    endtask

    task automatic csr_access(input logic we, input logic [7:0] off, input logic [31:0] d,
                              output logic [31:0] q);
        int n;
        tick(1);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = C_BASE | {24'h0, off}; wbs_dat_i = d;
        n = 0;
        do begin tick(1); n++; end while (!wbs_ack_o && n < 8);
        check_eq("csr_ack", {31'b0, wbs_ack_o}, 32'h1);
        q = wbs_dat_o;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic csr_write(input logic [7:0] off, input logic [31:0] d);
        logic [31:0] q;
        csr_access(1'b1, off, d, q);
    endtask

    task automatic clear_logs(input logic [31:0] seed);
        rx.delete(); req_adr.delete(); req_beats.delete();
        beat_total = 0; slv_seed = seed; slv_cnt = 0;
    endtask

    task automatic start_xfer(input logic [31:0] src, input logic [31:0] len,
                              input logic [31:0] seed);
        clear_logs(seed);
        csr_write(CSR_SRC, src);
        csr_write(CSR_LEN, len);
        csr_write(CSR_CTRL, 32'h1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        tick(2);
        n = 0;
        while (!irq_done && n < budget) begin tick(1); n++; end
        check_eq(tag, {31'b0, irq_done}, 32'h1);
        tick(4);
    endtask

    task automatic wait_beats(input int target, input int budget);
        int n;
        n = 0;
        while (beat_total < target && n < budget) begin tick(1); n++; end
        check_eq("beat_wait", {31'b0, beat_total >= target}, 32'h1);
    endtask

    task automatic check_words(input string tag, input int n, input logic [31:0] seed);
        check_eq({tag, "_cnt"}, rx.size(), n);
        for (int i = 0; i < n && i < rx.size(); i++)
            check_eq(tag, rx[i], seed + i);
    endtask

    // SDRAM slave: first beat 3 cycles after stb rises, then streams beats until cyc drops.
    initial begin
        dma_ack_i = 1'b0; dma_brust_i = 1'b0; dma_dat_i = '0;
        forever begin
            tick(1);
            if (dma_cyc_o) begin
                tick(2);
                if (dma_cyc_o) begin
                    dma_ack_i = 1'b1; dma_dat_i = slv_seed + slv_cnt; slv_cnt++;
                    tick(1);
                    dma_ack_i = 1'b0;
                    while (dma_cyc_o) begin
                        dma_brust_i = 1'b1; dma_dat_i = slv_seed + slv_cnt; slv_cnt++;
                        tick(1);
                    end
                    dma_brust_i = 1'b0; dma_dat_i = '0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge wb_clk_i);
            if (dma_cyc_o && !mon_prev_cyc) begin
                req_adr.push_back(dma_adr_o);
                req_beats.push_back(0);
            end
            if (dma_cyc_o && (dma_ack_i || dma_brust_i) && req_beats.size() > 0) begin
                req_beats[req_beats.size()-1] = req_beats[req_beats.size()-1] + 1;
                beat_total++;
            end
            mon_prev_cyc = dma_cyc_o;
            if (m_valid && m_ready) rx.push_back(m_data);
            if (u_dut.w_fifo_push && u_dut.w_fifo_full) ovf_seen = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int sum;
        tick(3);
        wb_rst_i = 1'b0;
        tick(1);

        // Reset state
        check_eq("rst_ctl", {24'b0, dma_cyc_o, dma_stb_o, dma_we_o, dma_fun_sel_o,
                             m_valid, irq_done, wbs_ack_o}, 32'h0);
        check_eq("rst_adr", dma_adr_o, 32'h0);
        check_eq("rst_mdata", m_data, 32'h0);
        csr_access(1'b0, CSR_STATUS, 32'h0, rd);
        check_eq("rst_status", rd, 32'h0);

        // Single beat with start-to-request latency
        m_ready = 1'b1;
        start_xfer(32'h0000_0100, 1, 32'hA5A5_0001);
        tick(1);
        check_eq("lat_cyc_n1", {31'b0, dma_cyc_o}, 32'h0);
        tick(1);
        check_eq("lat_cyc_n2", {31'b0, dma_cyc_o}, 32'h1);
        check_eq("single_adr", dma_adr_o, 32'h0000_0100);
        check_eq("single_fun", {30'b0, dma_fun_sel_o}, 32'h1);
        wait_done("single_done", 200);
        check_words("single_word", 1, 32'hA5A5_0001);
        csr_access(1'b0, CSR_STATUS, 32'h0, rd);
        check_eq("single_status", rd, 32'h2);
        check_eq("single_fun_idle", {30'b0, dma_fun_sel_o}, 32'h0);

        // Burst of 20, with a START (and a LEN rewrite) landing while busy
        start_xfer(32'h7800_0000, 20, 32'h1000_0000);
        wait_beats(1, 100);
        csr_write(CSR_LEN, 32'd5);
        csr_write(CSR_CTRL, 32'h1);
        wait_done("burst_done", 500);
        check_eq("burst_nreq", req_adr.size(), 3);
        if (req_adr.size() == 3) begin
            check_eq("burst_adr0", req_adr[0], 32'h7800_0000);
            check_eq("burst_adr1", req_adr[1], 32'h7800_0020);
            check_eq("burst_adr2", req_adr[2], 32'h7800_0040);
            check_eq("burst_beats0", req_beats[0], 8);
            check_eq("burst_beats1", req_beats[1], 8);
            check_eq("burst_beats2", req_beats[2], 4);
        end
        check_words("burst_word", 20, 32'h1000_0000);
        csr_access(1'b0, CSR_STATUS, 32'h0, rd);
        check_eq("burst_status", rd, 32'h2);

        // Backpressure: 16 buffered, then stalled until the consumer drains
        m_ready = 1'b0;
        start_xfer(32'h7800_1000, 40, 32'h2000_0000);
        tick(150);
        check_eq("bp_beats", beat_total, 16);
        check_eq("bp_cyc", {31'b0, dma_cyc_o}, 32'h0);
        check_eq("bp_valid", {31'b0, m_valid}, 32'h1);
        csr_access(1'b0, CSR_STATUS, 32'h0, rd);
        check_eq("bp_status", rd, 32'h1);
        m_ready = 1'b1;
        wait_done("bp_done", 2000);
        check_words("bp_word", 40, 32'h2000_0000);

        // LEN == 0
        clear_logs(32'h0);
        csr_write(CSR_LEN, 32'd0);
        csr_write(CSR_CTRL, 32'h1);
        tick(6);
        csr_access(1'b0, CSR_STATUS, 32'h0, rd);
        check_eq("len0_status", rd, 32'h6);
        check_eq("len0_irq", {31'b0, irq_done}, 32'h1);
        check_eq("len0_nreq", req_adr.size(), 0);

        // Abort after 5 beats, then a fresh transfer
        m_ready = 1'b0;
        start_xfer(32'h7800_2000, 16, 32'h3000_0000);
        wait_beats(5, 200);
        csr_write(CSR_CTRL, 32'h2);
        tick(1);
        check_eq("abort_cyc", {31'b0, dma_cyc_o}, 32'h0);
        check_eq("abort_flush", {31'b0, m_valid}, 32'h0);
        tick(3);
        csr_access(1'b0, CSR_STATUS, 32'h0, rd);
        check_eq("abort_status", rd, 32'h6);
        m_ready = 1'b1;
        start_xfer(32'h0000_0100, 2, 32'h4000_0000);
        wait_done("post_abort_done", 300);
        check_words("post_abort_word", 2, 32'h4000_0000);
        csr_access(1'b0, CSR_STATUS, 32'h0, rd);
        check_eq("post_abort_status", rd, 32'h2);

        // Reset in the middle of a burst
        m_ready = 1'b0;
        start_xfer(32'h7800_3000, 16, 32'h5000_0000);
        wait_beats(3, 200);
        wb_rst_i = 1'b1;
        tick(1);
        check_eq("mrst_ctl", {24'b0, dma_cyc_o, dma_stb_o, dma_we_o, dma_fun_sel_o,
                              m_valid, irq_done, wbs_ack_o}, 32'h0);
        check_eq("mrst_adr", dma_adr_o, 32'h0);
        check_eq("mrst_mdata", m_data, 32'h0);
        wb_rst_i = 1'b0;
        csr_access(1'b0, CSR_STATUS, 32'h0, rd);
        check_eq("mrst_status", rd, 32'h0);

        // Address wrap inside the 23-bit window
        m_ready = 1'b1;
        start_xfer(32'h007F_FFF8, 4, 32'h6000_0000);
        wait_done("wrap_done", 500);
        check_eq("wrap_nreq", req_adr.size(), 4);
        if (req_adr.size() == 4) begin
            check_eq("wrap_adr0", req_adr[0], 32'h007F_FFF8);
            check_eq("wrap_adr1", req_adr[1], 32'h007F_FFFC);
            check_eq("wrap_adr2", req_adr[2], 32'h0000_0000);
            check_eq("wrap_adr3", req_adr[3], 32'h0000_0004);
        end
        sum = 0;
        foreach (req_beats[i]) sum += req_beats[i];
        check_eq("wrap_beats", sum, 4);
        check_words("wrap_word", 4, 32'h6000_0000);
        csr_access(1'b0, CSR_STATUS, 32'h0, rd);
        check_eq("wrap_status", rd, 32'h6);

        check_eq("fifo_overflow", {31'b0, ovf_seen}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
